muldiv_ctrl: RTL and testbench

Sequencing controller for the iterative multiply/divide unit that serves MULT, MULTU, DIV and DIVU in the execute stage. It accepts one operation at a time from E and runs a radix‑2 shift‑add or restoring‑divide loop for WIDTH cycles. While the loop runs it holds the pipeline through a stall output that the hazard unit ORs into stallF/stallD and an E‑stage hold. On completion it delivers the HI/LO result to the HI/LO register with a one‑cycle write pulse.

---
 rtl/mips_pkg.sv | 17 +
 rtl/muldiv_datapath.sv | 99 +++++++++
 rtl/muldiv_ctrl.sv | 92 +++++++++
 tb/tb_muldiv_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core types for the multiply/divide unit.
package mips_pkg;

  typedef enum logic [1:0] {
    MDU_OP_MULT  = 2'b00,
    MDU_OP_MULTU = 2'b01,
    MDU_OP_DIV   = 2'b10,
    MDU_OP_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiply / restoring divide datapath with combinational
// sign fix on the registered magnitude result.
module muldiv_datapath
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // acc holds {hi accumulator, multiplier} for multiply and {rem, quot} for divide
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               isDiv, negQ, negR;

  logic               isSigned, signA, signB, opDiv;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     sum, shRem;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] accStep, prodFix;
  logic [WIDTH-1:0]   remRaw, quotRaw;

  always_comb begin
    opDiv    = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    isSigned = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    signA    = isSigned & srca[WIDTH-1];
    signB    = isSigned & srcb[WIDTH-1];
    absA     = signA ? -srca : srca;
    absB     = signB ? -srcb : srcb;
    divZero  = opDiv && (srcb == '0);
  end

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    shRem = acc[2*WIDTH-1:WIDTH-1];
    diff  = shRem[WIDTH-1:0] - opnd;
    if (isDiv) begin
      // shRem can carry one bit past WIDTH, so compare at WIDTH+1 bits
      if (shRem >= {1'b0, opnd}) accStep = {diff, acc[WIDTH-2:0], 1'b1};
      else                       accStep = {shRem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      accStep = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc   <= '0;
      opnd  <= '0;
      isDiv <= 1'b0;
      negQ  <= 1'b0;
      negR  <= 1'b0;
    end else if (load) begin
      isDiv <= opDiv;
      if (divZero) begin
        // Divide by zero: result preloaded, no sign fix
        acc  <= {srca, {WIDTH{1'b1}}};
        opnd <= '0;
        negQ <= 1'b0;
        negR <= 1'b0;
      end else if (opDiv) begin
        acc  <= {{WIDTH{1'b0}}, absA};
        opnd <= absB;
        negQ <= signA ^ signB;
        negR <= signA;
      end else begin
        acc  <= {{WIDTH{1'b0}}, absB};
        opnd <= absA;
        negQ <= signA ^ signB;
        negR <= 1'b0;
      end
    end else if (step) begin
      acc <= accStep;
    end
  end

  always_comb begin
    prodFix = negQ ? -acc : acc;
    remRaw  = acc[2*WIDTH-1:WIDTH];
    quotRaw = acc[WIDTH-1:0];
    if (isDiv) begin
      hi = negR ? -remRaw : remRaw;
      lo = negQ ? -quotRaw : quotRaw;
    end else begin
      hi = prodFix[2*WIDTH-1:WIDTH];
      lo = prodFix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencing FSM for the iterative MDU: accepts one op from E, stalls the
// pipeline for WIDTH iterations, then pulses the HI/LO write.
module muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  output logic             stall_mdu,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_t       state, stateNxt;
  logic [CW-1:0]    cnt, cntNxt;
  logic             accept, step, divZero;
  logic [WIDTH-1:0] dpHi, dpLo;

  // Gated by resetn so every output reads 0 while reset is held
  assign accept = resetn && (state == IDLE) && startE && !flushE;
  assign step   = (state == RUN) && !flushE;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    stall_mdu = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      IDLE: begin
        stall_mdu = accept;
        if (accept) begin
          cntNxt   = CW'(WIDTH - 1);
          stateNxt = divZero ? DONE : RUN;
        end
      end
      RUN: begin
        stall_mdu = 1'b1;
        if (flushE) begin
          stateNxt = IDLE;
          cntNxt   = '0;
        end else if (cnt == '0) begin
          stateNxt = DONE;
        end else begin
          cntNxt = cnt - 1'b1;
        end
      end
      DONE: begin
        hilo_we  = !flushE;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .resetn  (resetn),
    .load    (accept),
    .step    (step),
    .op      (mdu_op_t'(opE)),
    .srca    (srcaE),
    .srcb    (srcbE),
    .divZero (divZero),
    .hi      (dpHi),
    .lo      (dpLo)
  );

  assign hi_o = hilo_we ? dpHi : '0;
  assign lo_o = hilo_we ? dpLo : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed + random bench for muldiv_ctrl with a HI/LO scoreboard queue.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         startE = 1'b0;
  logic         flushE = 1'b0;
  logic [1:0]   opE = 2'b00;
  logic [W-1:0] srcaE = '0, srcbE = '0;
  logic         stall_mdu, busy, hilo_we;
  logic [W-1:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbq[$];

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .flushE(flushE),
    .stall_mdu(stall_mdu), .busy(busy), .hilo_we(hilo_we),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Issue one op and follow it cycle by cycle; cycle 0 is the accept cycle.
  task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp, input int flushAt, input string tag);
    int  doneCyc, expStall, lastCyc, stallCnt, weCnt, weCyc;
    bit  prevStall, flushed, dz, expectWe;
    logic [63:0] got;
    dz       = op[1] && (b == 0);
    doneCyc  = dz ? 1 : W + 1;
    expectWe = (flushAt < 0) || (flushAt > doneCyc);
    expStall = dz ? 1 : W + 1;
    if (flushAt >= 0 && flushAt < expStall) expStall = (flushAt == 0) ? 0 : flushAt + 1;
    lastCyc  = (flushAt >= 0) ? W + 6 : doneCyc;
    if (expectWe) sbq.push_back(exp);
    prevStall = 1'b0; flushed = 1'b0;
    stallCnt = 0; weCnt = 0; weCyc = -1;
    for (int c = 0; c <= lastCyc; c++) begin
      @(negedge clk);
      flushE = (c == flushAt);
      if (flushE) flushed = 1'b1;
      startE = !flushed && ((c == 0) || prevStall);
      opE = op; srcaE = a; srcbE = b;
      #1;
      prevStall = stall_mdu;
      if (stall_mdu) stallCnt++;
      if (flushAt >= 0 && c == flushAt + 1) check({tag, " busy after flush"}, {63'b0, busy}, 64'd0);
      if (hilo_we) begin
        weCnt++;
        if (weCyc < 0) weCyc = c;
        if (sbq.size() == 0) check({tag, " unexpected hilo_we"}, {63'b0, hilo_we}, 64'd0);
        else begin
          got = sbq.pop_front();
          check({tag, " hilo"}, {hi_o, lo_o}, got);
        end
      end
    end
    startE = 1'b0;
    flushE = 1'b0;
    check({tag, " stall cycles"}, 64'(stallCnt), 64'(expStall));
    check({tag, " we cycle"}, 64'(weCyc), expectWe ? 64'(doneCyc) : 64'(-1));
    check({tag, " we count"}, 64'(weCnt), expectWe ? 64'd1 : 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          pv;

    #2 resetn = 1'b0;
    #1;
    check("reset outputs", {61'b0, stall_mdu, busy, hilo_we}, 64'd0);
    check("reset hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    doOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1, "multu_max");
    doOp(2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, -1, "mult_neg");
    doOp(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, -1, "div_neg");
    doOp(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, -1, "divu");
    doOp(2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, -1, "divu_zero");
    doOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, -1, "div_ovf");
    doOp(2'b00, 32'd5, 32'd6, 64'd30, 10, "mult_flush10");
    doOp(2'b00, 32'd5, 32'd6, 64'd30, W + 1, "mult_flush_done");

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 2) ? 32'd0 : $urandom;
      doOp(rop, ra, rb, model(rop, ra, rb), -1, "random");
    end

    // Asynchronous reset in the middle of a DIV
    pv = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      startE = (c == 0) || pv;
      opE = 2'b10; srcaE = 32'hFFFF_FF9C; srcbE = 32'd3;
      #1 pv = stall_mdu;
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset busy/stall/we", {61'b0, busy, stall_mdu, hilo_we}, 64'd0);
    @(negedge clk);
    startE = 1'b0;
    #1 check("midreset held", {61'b0, busy, stall_mdu, hilo_we}, 64'd0);
    resetn = 1'b1;
    doOp(2'b01, 32'd2, 32'd3, 64'd6, -1, "multu_after_reset");

    check("scoreboard empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
